// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_feeder
// Brief    : Loads N A/B vectors from a byte stream, then skews them into the
//            N x N systolic array and sequences clear, flush and readout.
// Revision : 1.0
// ============================================================================
module systolic_feeder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] arr_in1,
    output logic [N-1:0] arr_in2,
    output logic         arr_clear,
    output logic         arr_readout,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] LAST_WORD  = CW'(2 * N - 1);
    localparam logic [CW-1:0] LAST_FEED  = CW'(2 * N - 2);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(N - 2);
    localparam logic [CW-1:0] LAST_READ  = CW'(N - 1);

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_CLEAR   = 3'd1,
        S_FEED    = 3'd2,
        S_DRAIN   = 3'd3,
        S_READOUT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [N-1:0]  a_q [N];
    logic [N-1:0]  b_q [N];
    logic          accept;

    assign in_ready    = ena & (state_q == S_LOAD);
    assign accept      = in_valid & in_ready;
    assign arr_clear   = (state_q == S_CLEAR);
    assign arr_readout = (state_q == S_READOUT);
    assign busy        = (state_q != S_LOAD);
    assign done        = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Word order is A0,B0,A1,B1,...: the count LSB selects the bank.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (!cnt_q[0]) a_q[cnt_q[CW-1:1]] <= in_data;
            else           b_q[cnt_q[CW-1:1]] <= in_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (!ena) begin
            state_d = S_LOAD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        if (cnt_q == LAST_WORD) begin
                            state_d = S_CLEAR;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    state_d = S_FEED;
                    cnt_d   = '0;
                end
                S_FEED: begin
                    if (cnt_q == LAST_FEED) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == LAST_DRAIN) begin
                        state_d = S_READOUT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_READOUT: begin
                    if (cnt_q == LAST_READ) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Diagonal skew: lane k carries vector (t-k), so lane k lags lane 0 by k.
    always_comb begin
        arr_in1 = '0;
        arr_in2 = '0;
        if (state_q == S_FEED) begin
            for (int j = 0; j < N; j++) begin
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CW'(j + k)) begin
                        arr_in1[k] = a_q[j][k];
                        arr_in2[k] = b_q[j][k];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_feeder
// Brief    : Directed self-checking bench for systolic_feeder (N=8).
// Revision : 1.0
// ============================================================================
module tb_systolic_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] arr_in1, arr_in2;
    logic       arr_clear, arr_readout, busy, done;

    int checks = 0;
    int errors = 0;

    logic [7:0] words [16];
    logic [7:0] exp1  [15];
    logic [7:0] exp2  [15];

    systolic_feeder #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .arr_in1    (arr_in1),
        .arr_in2    (arr_in2),
        .arr_clear  (arr_clear),
        .arr_readout(arr_readout),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_vectors();
        for (int i = 0; i < 16; i++) words[i] = 8'h00;
        for (int i = 0; i < 15; i++) begin
            exp1[i] = 8'h00;
            exp2[i] = 8'h00;
        end
    endtask

    task automatic load16();
        for (int i = 0; i < 16; i++) begin
            in_data  = words[i];
            in_valid = 1'b1;
            check("load_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        check("clear_ready", in_ready, 0);
        check("clear_pulse", arr_clear, 1);
        check("clear_busy", busy, 1);
    endtask

    task automatic load_gapped();
        for (int i = 0; i < 16; i++) begin
            in_data  = words[i];
            in_valid = 1'b1;
            check("gap_ready", in_ready, 1);
            step();
            if (i < 15) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
                step();
            end
        end
        in_valid = 1'b0;
        check("gap_clear_pulse", arr_clear, 1);
    endtask

    // Entered in the CLEAR cycle; returns in the done cycle.
    task automatic run_job(input bit hold_valid);
        check("clear_in1", arr_in1, 0);
        check("clear_in2", arr_in2, 0);
        if (hold_valid) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
        end
        step();
        for (int t = 0; t < 15; t++) begin
            check($sformatf("feed_in1_t%0d", t), arr_in1, exp1[t]);
            check($sformatf("feed_in2_t%0d", t), arr_in2, exp2[t]);
            check("feed_clear", arr_clear, 0);
            check("feed_ready", in_ready, 0);
            step();
        end
        for (int d = 0; d < 7; d++) begin
            check("drain_in1", arr_in1, 0);
            check("drain_in2", arr_in2, 0);
            check("drain_readout", arr_readout, 0);
            step();
        end
        for (int r = 0; r < 8; r++) begin
            check("readout_en", arr_readout, 1);
            check("readout_busy", busy, 1);
            check("readout_done", done, 0);
            step();
        end
        in_valid = 1'b0;
        check("done_pulse", done, 1);
        check("done_ready", in_ready, 1);
        check("done_busy", busy, 0);
        check("done_readout", arr_readout, 0);
    endtask

    initial begin
        int dones;

        // Reset values
        #12;
        check("rst_ready", in_ready, 1);
        check("rst_in1", arr_in1, 0);
        check("rst_in2", arr_in2, 0);
        check("rst_clear", arr_clear, 0);
        check("rst_readout", arr_readout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back load, single-bit-lane skew of A0=FF, full timing
        clear_vectors();
        words[0] = 8'hFF;
        for (int t = 0; t < 8; t++) exp1[t] = 8'(1 << t);
        load16();
        run_job(1'b0);

        // Gapped load (starts on the done cycle), B ordering, in_valid during FEED
        clear_vectors();
        words[1]  = 8'h81;   // B0
        words[2]  = 8'h03;   // A1
        words[14] = 8'h80;   // A7
        words[15] = 8'h01;   // B7
        exp1[1]  = 8'h01;
        exp1[2]  = 8'h02;
        exp1[14] = 8'h80;
        exp2[0]  = 8'h01;
        exp2[7]  = 8'h81;
        load_gapped();
        run_job(1'b1);
        step();
        check("post_done_low", done, 0);

        // Abort after 5 accepted words
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 5; i++) step();
        ena = 1'b0;
        #1;
        check("abort_ready", in_ready, 0);
        step();
        ena      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("abort_ready_back", in_ready, 1);
        check("abort_busy", busy, 0);
        clear_vectors();
        words[7] = 8'h10;    // B3
        exp2[7]  = 8'h10;
        load16();
        run_job(1'b0);

        // Asynchronous reset during FEED t=4
        clear_vectors();
        words[0] = 8'hFF;
        load16();
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_in1_t4", arr_in1, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in1", arr_in1, 0);
        check("arst_in2", arr_in2, 0);
        check("arst_clear", arr_clear, 0);
        check("arst_readout", arr_readout, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_ready", in_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) dones++;
            step();
        end
        check("arst_no_done", dones, 0);
        check("arst_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
